// File: rtl/orientation_histogram.sv
// ============================================================================
//  Module      : orientation_histogram
//  Description : Streams a WIN x WIN gradient patch around a keypoint and
//                accumulates L1 magnitudes into 8 orientation bins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module orientation_histogram #(
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 64,
    parameter int BIT_DEPTH = 8,
    parameter int WIN       = 4,
    localparam int ACC_WIDTH = BIT_DEPTH + 1 + 2 * $clog2(WIN)
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [$clog2(WIDTH)-1:0]          kp_x,
    input  logic [$clog2(HEIGHT)-1:0]         kp_y,
    input  logic                              kp_valid,
    output logic                              kp_ready,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   grad_read_addr,
    output logic                              grad_read_valid,
    input  logic [BIT_DEPTH-1:0]              x_grad_in,
    input  logic [BIT_DEPTH-1:0]              y_grad_in,
    output logic [8*ACC_WIDTH-1:0]            hist_bins,
    output logic                              hist_valid
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int CW = $clog2(WIN);
    localparam int MW = BIT_DEPTH + 1;

    localparam logic [XW-1:0] c_HALF_X   = XW'(WIN / 2);
    localparam logic [YW-1:0] c_HALF_Y   = YW'(WIN / 2);
    localparam logic [XW-1:0] c_MAX_X0   = XW'(WIDTH - WIN);
    localparam logic [YW-1:0] c_MAX_Y0   = YW'(HEIGHT - WIN);
    localparam logic [AW-1:0] c_ROW_STEP = AW'(WIDTH - WIN + 1);
    localparam logic [CW-1:0] c_LAST     = CW'(WIN - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_accept;
    logic [XW-1:0]         w_x0;
    logic [YW-1:0]         w_y0;
    logic [AW-1:0]         w_origin_addr;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_row;
    logic                  w_last_addr;
    logic [1:0]            r_vpipe;
    logic [MW-1:0]         w_gx_ext;
    logic [MW-1:0]         w_gy_ext;
    logic [MW-1:0]         w_ax;
    logic [MW-1:0]         w_ay;
    logic [MW-1:0]         w_mag;
    logic [1:0]            w_quad;
    logic [2:0]            w_sel;
    logic [ACC_WIDTH-1:0]  r_bins [8];

    assign w_accept = (r_state == c_IDLE) && kp_valid;

    // Patch origin is clamped so the whole window stays inside the image.
    always_comb begin
        w_x0 = kp_x - c_HALF_X;
        if (kp_x < c_HALF_X)
            w_x0 = '0;
        else if ((kp_x - c_HALF_X) > c_MAX_X0)
            w_x0 = c_MAX_X0;

        w_y0 = kp_y - c_HALF_Y;
        if (kp_y < c_HALF_Y)
            w_y0 = '0;
        else if ((kp_y - c_HALF_Y) > c_MAX_Y0)
            w_y0 = c_MAX_Y0;
    end

    assign w_origin_addr = (AW'(w_y0) * AW'(WIDTH)) + AW'(w_x0);
    assign w_last_addr   = (r_col == c_LAST) && (r_row == c_LAST);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_state <= c_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; the pipe draining (stage 1 set, stage 0 clear) marks the last sample
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (kp_valid) w_state_next = c_STREAM;
            c_STREAM: if (r_vpipe[1] && !r_vpipe[0]) w_state_next = c_DONE;
            c_DONE:   w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        kp_ready   = (r_state == c_IDLE);
        hist_valid = (r_state == c_DONE);
    end

    // Address generator and read-latency tracking
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            grad_read_addr  <= '0;
            grad_read_valid <= 1'b0;
            r_col           <= '0;
            r_row           <= '0;
            r_vpipe         <= '0;
        end else begin
            r_vpipe <= {r_vpipe[0], grad_read_valid};
            if (w_accept) begin
                grad_read_addr  <= w_origin_addr;
                grad_read_valid <= 1'b1;
                r_col           <= '0;
                r_row           <= '0;
            end else if (grad_read_valid) begin
                if (w_last_addr) begin
                    grad_read_valid <= 1'b0;
                end else if (r_col == c_LAST) begin
                    r_col          <= '0;
                    r_row          <= r_row + CW'(1);
                    grad_read_addr <= grad_read_addr + c_ROW_STEP;
                end else begin
                    r_col          <= r_col + CW'(1);
                    grad_read_addr <= grad_read_addr + AW'(1);
                end
            end
        end
    end

    // Sign-extend by one bit so |-2^(B-1)| is representable.
    assign w_gx_ext = {x_grad_in[BIT_DEPTH-1], x_grad_in};
    assign w_gy_ext = {y_grad_in[BIT_DEPTH-1], y_grad_in};
    assign w_ax     = x_grad_in[BIT_DEPTH-1] ? (~w_gx_ext + MW'(1)) : w_gx_ext;
    assign w_ay     = y_grad_in[BIT_DEPTH-1] ? (~w_gy_ext + MW'(1)) : w_gy_ext;
    assign w_mag    = w_ax + w_ay;

    // Quadrants 0..3 counter-clockwise; odd quadrants place the tie in the upper bin.
    assign w_quad = {y_grad_in[BIT_DEPTH-1], x_grad_in[BIT_DEPTH-1] ^ y_grad_in[BIT_DEPTH-1]};
    assign w_sel  = {w_quad, (w_quad[0] ? (w_ax >= w_ay) : (w_ax < w_ay))};

    generate
        for (genvar k = 0; k < 8; k++) begin : g_bin
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in)
                    r_bins[k] <= '0;
                else if (w_accept)
                    r_bins[k] <= '0;
                else if (r_vpipe[1] && (w_sel == 3'(k)))
                    r_bins[k] <= r_bins[k] + ACC_WIDTH'(w_mag);
            end
            assign hist_bins[k*ACC_WIDTH +: ACC_WIDTH] = r_bins[k];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_orientation_histogram.sv
// ============================================================================
//  Module      : tb_orientation_histogram
//  Description : Directed self-checking bench for orientation_histogram.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_orientation_histogram;

    localparam int ACC = 13;

    logic               clk_in;
    logic               rst_in;
    logic [5:0]         kp_x;
    logic [5:0]         kp_y;
    logic               kp_valid;
    logic               kp_ready;
    logic [11:0]        grad_read_addr;
    logic               grad_read_valid;
    logic [7:0]         x_grad_in;
    logic [7:0]         y_grad_in;
    logic [8*ACC-1:0]   hist_bins;
    logic               hist_valid;

    orientation_histogram #(
        .WIDTH(64), .HEIGHT(64), .BIT_DEPTH(8), .WIN(4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .kp_x            (kp_x),
        .kp_y            (kp_y),
        .kp_valid        (kp_valid),
        .kp_ready        (kp_ready),
        .grad_read_addr  (grad_read_addr),
        .grad_read_valid (grad_read_valid),
        .x_grad_in       (x_grad_in),
        .y_grad_in       (y_grad_in),
        .hist_bins       (hist_bins),
        .hist_valid      (hist_valid)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Two-cycle-latency BRAM model
    logic [7:0] xmem [0:4095];
    logic [7:0] ymem [0:4095];
    logic [7:0] xd1, xd2, yd1, yd2;
    always @(posedge clk_in) begin
        xd1 <= xmem[grad_read_addr];
        yd1 <= ymem[grad_read_addr];
        xd2 <= xd1;
        yd2 <= yd1;
    end
    assign x_grad_in = xd2;
    assign y_grad_in = yd2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          hv_first;
    int          hv_cnt;
    bit          ready_bad;
    logic        rdy20, gv21;
    longint      bsum21;
    logic [11:0] addr_log [1:22];
    logic        av_log [1:22];
    longint      snap [8];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint bin(input int k);
        return longint'(hist_bins[k*ACC +: ACC]);
    endfunction

    function automatic longint bsum();
        longint s = 0;
        for (int k = 0; k < 8; k++) s += bin(k);
        return s;
    endfunction

    task automatic fill(input int gx, input int gy);
        for (int a = 0; a < 4096; a++) begin
            xmem[a] = gx[7:0];
            ymem[a] = gy[7:0];
        end
    endtask

    // Rows above 20 hold (+4,+1); rows 20 and below hold (-1,-6).
    task automatic fill_mixed();
        for (int a = 0; a < 4096; a++) begin
            xmem[a] = (a / 64 < 20) ? 8'h04 : 8'hFF;
            ymem[a] = (a / 64 < 20) ? 8'h01 : 8'hFA;
        end
    endtask

    // Handshake = cycle 0, then observe cycles 1..22 at the falling edge.
    task automatic run_kp(input int x, input int y, input bit hold);
        @(negedge clk_in);
        kp_x = x[5:0];
        kp_y = y[5:0];
        kp_valid = 1'b1;
        chk("kp_ready_before_handshake", kp_ready, 1);
        @(posedge clk_in);
        hv_first  = -1;
        hv_cnt    = 0;
        ready_bad = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk_in);
            if (!hold) kp_valid = 1'b0;
            av_log[c]   = grad_read_valid;
            addr_log[c] = grad_read_addr;
            if (hist_valid) begin
                hv_cnt++;
                if (hv_first < 0) begin
                    hv_first = c;
                    for (int k = 0; k < 8; k++) snap[k] = bin(k);
                end
            end
            if (c <= 19 && kp_ready) ready_bad = 1;
            if (c == 20) rdy20 = kp_ready;
            if (c == 21) begin
                gv21   = grad_read_valid;
                bsum21 = bsum();
            end
        end
    endtask

    int tgx [4] = '{-5, 3, 0, -128};
    int tgy [4] = '{5, -7, 0, -128};
    int tbn [4] = '{3, 6, 0, 4};
    int tvl [4] = '{160, 160, 0, 4096};

    initial begin
        rst_in   = 1'b1;
        kp_valid = 1'b0;
        kp_x     = '0;
        kp_y     = '0;
        fill(0, 0);
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_kp_ready", kp_ready, 1);
        chk("rst_grad_read_valid", grad_read_valid, 0);
        chk("rst_hist_valid", hist_valid, 0);
        chk("rst_bins", bsum(), 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Uniform +x gradient
        fill(10, 0);
        run_kp(20, 20, 0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("east_bin%0d", k), snap[k], (k == 0) ? 160 : 0);
        chk("east_hv_cycle", hv_first, 19);
        chk("east_hv_count", hv_cnt, 1);
        chk("east_ready_low", ready_bad, 0);
        chk("east_ready_c20", rdy20, 1);
        chk("east_first_addr", addr_log[1], 18 * 64 + 18);
        chk("east_av_c1", av_log[1], 1);
        chk("east_av_c16", av_log[16], 1);
        chk("east_av_c17", av_log[17], 0);
        repeat (3) @(negedge clk_in);
        chk("east_hold_bin0", bin(0), 160);

        // Quadrant / tie / zero / extreme cases
        for (int t = 0; t < 4; t++) begin
            fill(tgx[t], tgy[t]);
            run_kp(20, 20, 0);
            for (int k = 0; k < 8; k++)
                chk($sformatf("tbl%0d_bin%0d", t, k), snap[k], (k == tbn[t]) ? tvl[t] : 0);
            chk($sformatf("tbl%0d_hv_cycle", t), hv_first, 19);
            chk($sformatf("tbl%0d_hv_count", t), hv_cnt, 1);
        end

        // Address sequence at the top-left corner
        fill(1, 1);
        run_kp(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("corner0_addr%0d", i), addr_log[1 + i], (i / 4) * 64 + (i % 4));
            chk($sformatf("corner0_av%0d", i), av_log[1 + i], 1);
        end
        chk("corner0_av_after", av_log[17], 0);

        // Bottom-right clamp
        run_kp(63, 63, 0);
        chk("corner63_first", addr_log[1], 3900);
        chk("corner63_last", addr_log[16], 4095);
        chk("corner63_hv_cycle", hv_first, 19);

        // Mixed patch, keypoint held for a back-to-back request
        fill_mixed();
        run_kp(20, 20, 1);
        chk("mixed_bin0", snap[0], 40);
        chk("mixed_bin5", snap[5], 56);
        chk("mixed_others", snap[1] + snap[2] + snap[3] + snap[4] + snap[6] + snap[7], 0);
        chk("mixed_hv_cycle", hv_first, 19);
        chk("b2b_ready_c20", rdy20, 1);
        chk("b2b_stream_c21", gv21, 1);
        chk("b2b_bins_cleared", bsum21, 0);
        kp_valid = 1'b0;
        begin
            bit seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk_in);
                if (hist_valid) seen = 1;
            end
            chk("b2b_hist_valid", seen, 1);
            chk("b2b_bin0", bin(0), 40);
            chk("b2b_bin5", bin(5), 56);
        end
        @(negedge clk_in);

        // Reset during STREAM
        fill(10, 0);
        @(negedge clk_in);
        kp_x = 6'd20;
        kp_y = 6'd20;
        kp_valid = 1'b1;
        @(posedge clk_in);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            kp_valid = 1'b0;
        end
        chk("midrst_partial_bin0", bin(0), 50);
        rst_in = 1'b1;
        #1;
        chk("midrst_grad_read_valid", grad_read_valid, 0);
        chk("midrst_hist_valid", hist_valid, 0);
        chk("midrst_bins", bsum(), 0);
        chk("midrst_kp_ready", kp_ready, 1);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("postrst_kp_ready", kp_ready, 1);
        begin
            int hv = 0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk_in);
                if (hist_valid) hv++;
            end
            chk("postrst_no_hist_valid", hv, 0);
        end
        run_kp(20, 20, 0);
        chk("postrst_bin0", snap[0], 160);
        chk("postrst_hv_cycle", hv_first, 19);
        chk("postrst_hv_count", hv_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
